// File: rtl/gray_to_binary_display.sv
// gray_to_binary_display
//
// Purpose:
//   Takes a 4-bit Gray code from board switches, synchronizes it, debounces it
//   and decodes it to binary. The result is shown as a hex glyph on a
//   seven-segment display.
//   A value is committed only after the synchronized input has held one value
//   for DEBOUNCE_CYCLES consecutive clk cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive cycles a new synchronized code must hold
//                     before it is committed (2..65535)
//
// Ports:
//   clk           - system clock
//   rst           - asynchronous, active-high reset
//   gray_in[3:0]  - raw Gray code, asynchronous to clk
//   err_clr       - synchronous clear of step_err
//   binary_out[3:0]    - registered binary value of the committed code
//   bin_valid          - one-cycle pulse when binary_out takes a committed value
//   seven_segment[6:0] - registered active-high segments {g,f,e,d,c,b,a}
//   step_err           - sticky flag: a commit moved by other than exactly one bit
//
// Configuration:
//   GRAY_STEP_CHECK_EN - when defined, builds the single-bit step checker that
//                        drives step_err. When undefined, step_err is tied
//                        low and err_clr is ignored.

module gray_to_binary_display #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] gray_in,
   input  logic       err_clr,
   output logic [3:0] binary_out,
   output logic       bin_valid,
   output logic [6:0] seven_segment,
   output logic       step_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  sync_meta_q, sync_meta_d;
   logic [3:0]  sync_q, sync_d;
   logic [3:0]  stable_q, stable_d;
   logic [3:0]  candidate_q, candidate_d;
   logic [15:0] counter_q, counter_d;
   logic [3:0]  binary_out_q, binary_out_d;
   logic        bin_valid_q, bin_valid_d;
   logic [6:0]  seven_segment_q, seven_segment_d;
   logic        commit;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   always_comb begin
      sync_meta_d = gray_in;
      sync_d      = sync_meta_q;

      state_d     = state_q;
      stable_d    = stable_q;
      candidate_d = candidate_q;
      counter_d   = counter_q;
      commit      = 1'b0;

      case (state_q)
         IDLE: begin
            if (sync_q != stable_q) begin
               state_d     = SETTLE;
               candidate_d = sync_q;
               counter_d   = '0;
            end
         end
         SETTLE: begin
            // A changed input restarts the count. A return to the committed
            // value abandons the change.
            if (sync_q != candidate_q) begin
               candidate_d = sync_q;
               counter_d   = '0;
            end else if (sync_q == stable_q) begin
               state_d = IDLE;
            end else if (counter_q == CNT_MAX) begin
               state_d = COMMIT;
            end else begin
               counter_d = counter_q + 16'd1;
            end
         end
         COMMIT: begin
            stable_d = candidate_q;
            commit   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // binary_out is loaded on the same edge as stable, so decode the value
      // that stable is about to take.
      binary_out_d    = commit ? gray_to_bin(stable_d) : binary_out_q;
      bin_valid_d     = commit;
      seven_segment_d = hex_glyph(binary_out_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta_q     <= '0;
         sync_q          <= '0;
         state_q         <= IDLE;
         stable_q        <= '0;
         candidate_q     <= '0;
         counter_q       <= '0;
         binary_out_q    <= '0;
         bin_valid_q     <= 1'b0;
         seven_segment_q <= 7'h3F;
      end else begin
         sync_meta_q     <= sync_meta_d;
         sync_q          <= sync_d;
         state_q         <= state_d;
         stable_q        <= stable_d;
         candidate_q     <= candidate_d;
         counter_q       <= counter_d;
         binary_out_q    <= binary_out_d;
         bin_valid_q     <= bin_valid_d;
         seven_segment_q <= seven_segment_d;
      end
   end

   assign binary_out    = binary_out_q;
   assign bin_valid     = bin_valid_q;
   assign seven_segment = seven_segment_q;

`ifdef GRAY_STEP_CHECK_EN
   logic step_err_q, step_err_d;
   logic step_bad;

   // A new error wins over a clear that arrives in the same cycle.
   always_comb begin
      step_bad   = commit && ($countones(candidate_q ^ stable_q) != 1);
      step_err_d = step_err_q;
      if (step_bad) begin
         step_err_d = 1'b1;
      end else if (err_clr) begin
         step_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_err_q <= 1'b0;
      end else begin
         step_err_q <= step_err_d;
      end
   end

   assign step_err = step_err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign step_err       = 1'b0;
`endif

endmodule

// File: tb/tb_gray_to_binary_display.sv
// Testbench for gray_to_binary_display (DEBOUNCE_CYCLES = 4).
// Directed vector table plus hand-written corner sequences, with a
// cycle-level reference model checked on every falling edge.

module tb_gray_to_binary_display;

   localparam int DEB = 4;
`ifdef GRAY_STEP_CHECK_EN
   localparam bit STEP_CHECK = 1'b1;
`else
   localparam bit STEP_CHECK = 1'b0;
`endif

   localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] gray_in = 4'b1010;
   logic       err_clr = 1'b0;
   logic [3:0] binary_out;
   logic       bin_valid;
   logic [6:0] seven_segment;
   logic       step_err;

   int n_checks = 0;
   int n_errors = 0;

   gray_to_binary_display #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk          (clk),
      .rst          (rst),
      .gray_in      (gray_in),
      .err_clr      (err_clr),
      .binary_out   (binary_out),
      .bin_valid    (bin_valid),
      .seven_segment(seven_segment),
      .step_err     (step_err)
   );

   always #5 clk = ~clk;

   // Reference model: counts how long the synchronized value has been seen
   // and commits once a new value has been held for DEB+1 evaluations.
   typedef struct packed {
      logic [3:0] d1, d2, stable, runval, pending, bin;
      logic [6:0] seg;
      logic       valid, err, blocked;
      logic [7:0] run;
   } model_t;

   model_t m;

   function automatic logic [3:0] gray_value(input logic [3:0] g);
      return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
   endfunction

   function automatic model_t model_reset();
      model_t n;
      n = '0;
      n.seg = 7'h3F;
      return n;
   endfunction

   function automatic model_t model_next(input model_t cur, input logic [3:0] g, input logic clr);
      model_t     n;
      logic [3:0] s;
      n       = cur;
      s       = cur.d2;
      n.d2    = cur.d1;
      n.d1    = g;
      n.seg   = GLYPH[cur.bin];
      n.valid = 1'b0;
      if (clr) n.err = 1'b0;
      if (cur.blocked) begin
         n.blocked = 1'b0;
         if (STEP_CHECK && ($countones(cur.pending ^ cur.stable) != 1)) n.err = 1'b1;
         n.stable = cur.pending;
         n.bin    = gray_value(cur.pending);
         n.valid  = 1'b1;
         n.run    = '0;
      end else if (s == cur.stable) begin
         n.run = '0;
      end else begin
         if (cur.run != 0 && s == cur.runval) begin
            n.run = 8'(cur.run + 8'd1);
         end else begin
            n.runval = s;
            n.run    = 8'd1;
         end
         if (int'(n.run) == DEB + 1) begin
            n.blocked = 1'b1;
            n.pending = s;
         end
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= model_reset();
      else     m <= model_next(m, gray_in, err_clr);
   end

   always @(negedge clk) begin
      n_checks++;
      if ({binary_out, bin_valid, seven_segment, step_err} !== {m.bin, m.valid, m.seg, m.err}) begin
         n_errors++;
         $display("[TB] FAIL model t=%0t: got bin=%h valid=%b seg=%h err=%b, expected bin=%h valid=%b seg=%h err=%b",
                  $time, binary_out, bin_valid, seven_segment, step_err, m.bin, m.valid, m.seg, m.err);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives a code (and an optional one-cycle err_clr) and counts bin_valid pulses.
   task automatic applyStimulus(input logic [3:0] g, input logic clr, input int n, output int pulses);
      gray_in = g;
      err_clr = clr;
      pulses  = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         err_clr = 1'b0;
         if (bin_valid) pulses++;
      end
   endtask

   task automatic reset_dut();
      gray_in = 4'b0000;
      err_clr = 1'b0;
      rst     = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
   endtask

   typedef struct {
      logic [3:0] gray;
      logic [3:0] bin;
      logic [6:0] seg;
   } vec_t;

   vec_t vecs [15];

   initial begin
      int p;
      int total;
      logic [3:0] g;

      // Full Gray walk, one bit per step, so step_err must stay low.
      vecs[0]  = '{4'b0001, 4'h1, 7'h06};
      vecs[1]  = '{4'b0011, 4'h2, 7'h5B};
      vecs[2]  = '{4'b0010, 4'h3, 7'h4F};
      vecs[3]  = '{4'b0110, 4'h4, 7'h66};
      vecs[4]  = '{4'b0111, 4'h5, 7'h6D};
      vecs[5]  = '{4'b0101, 4'h6, 7'h7D};
      vecs[6]  = '{4'b0100, 4'h7, 7'h07};
      vecs[7]  = '{4'b1100, 4'h8, 7'h7F};
      vecs[8]  = '{4'b1101, 4'h9, 7'h6F};
      vecs[9]  = '{4'b1111, 4'hA, 7'h77};
      vecs[10] = '{4'b1110, 4'hB, 7'h7C};
      vecs[11] = '{4'b1010, 4'hC, 7'h39};
      vecs[12] = '{4'b1011, 4'hD, 7'h5E};
      vecs[13] = '{4'b1001, 4'hE, 7'h79};
      vecs[14] = '{4'b1000, 4'hF, 7'h71};

      $display("[TB] reset with gray_in=1010");
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("rst_bin",   7'(binary_out), 7'h00);
         checkOutput("rst_seg",   seven_segment,  7'h3F);
         checkOutput("rst_valid", 7'(bin_valid),  7'h00);
         checkOutput("rst_err",   7'(step_err),   7'h00);
      end

      $display("[TB] latency 0000 -> 0100");
      reset_dut();
      applyStimulus(4'b0100, 1'b0, 7, p);
      checkOutput("lat_bin_e7",   7'(binary_out), 7'h00);
      checkOutput("lat_valid_e7", 7'(bin_valid),  7'h00);
      tick();
      if (bin_valid) p++;
      checkOutput("lat_bin_e8",   7'(binary_out), 7'h07);
      checkOutput("lat_valid_e8", 7'(bin_valid),  7'h01);
      checkOutput("lat_seg_e8",   seven_segment,  7'h3F);
      tick();
      if (bin_valid) p++;
      checkOutput("lat_seg_e9",   seven_segment,  7'h07);
      checkOutput("lat_valid_e9", 7'(bin_valid),  7'h00);
      checkOutput("lat_err",      7'(step_err),   7'h00);
      applyStimulus(4'b0100, 1'b0, 4, total);
      checkOutput("lat_pulses", 7'(p + total), 7'h01);

      $display("[TB] vector table");
      reset_dut();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].gray, 1'b0, 12, p);
         checkOutput($sformatf("vec%0d_bin", i), 7'(binary_out), 7'(vecs[i].bin));
         checkOutput($sformatf("vec%0d_seg", i), seven_segment, vecs[i].seg);
         checkOutput($sformatf("vec%0d_err", i), 7'(step_err), 7'h00);
         checkOutput($sformatf("vec%0d_pulses", i), 7'(p), 7'h01);
      end

      $display("[TB] bounce shorter than debounce");
      reset_dut();
      total = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b0001, 1'b0, 2, p);
         total += p;
         applyStimulus(4'b0000, 1'b0, 2, p);
         total += p;
      end
      applyStimulus(4'b0000, 1'b0, 10, p);
      total += p;
      checkOutput("bounce_pulses", 7'(total), 7'h00);
      checkOutput("bounce_bin", 7'(binary_out), 7'h00);

      $display("[TB] step error set and clear");
      reset_dut();
      applyStimulus(4'b0011, 1'b0, 12, p);
      checkOutput("step_bin", 7'(binary_out), 7'h02);
      checkOutput("step_err_set", 7'(step_err), 7'(STEP_CHECK));
      applyStimulus(4'b0011, 1'b1, 3, p);
      checkOutput("step_err_clr1", 7'(step_err), 7'h00);
      applyStimulus(4'b0000, 1'b0, 7, p);
      checkOutput("step_pre_commit_pulses", 7'(p), 7'h00);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checkOutput("step_commit_valid", 7'(bin_valid), 7'h01);
      checkOutput("step_commit_bin", 7'(binary_out), 7'h00);
      checkOutput("step_set_wins", 7'(step_err), 7'(STEP_CHECK));
      applyStimulus(4'b0000, 1'b0, 3, p);
      checkOutput("step_sticky", 7'(step_err), 7'(STEP_CHECK));
      applyStimulus(4'b0000, 1'b1, 2, p);
      checkOutput("step_err_clr2", 7'(step_err), 7'h00);

      $display("[TB] reset during settle and commit");
      reset_dut();
      applyStimulus(4'b1000, 1'b0, 12, p);
      checkOutput("r_bin_f", 7'(binary_out), 7'h0F);
      checkOutput("r_seg_f", seven_segment, 7'h71);
      applyStimulus(4'b1001, 1'b0, 4, p);
      checkOutput("r_settle_pulses", 7'(p), 7'h00);
      checkOutput("r_settle_bin", 7'(binary_out), 7'h0F);
      rst = 1'b1;
      #1;
      checkOutput("r_async_bin", 7'(binary_out), 7'h00);
      checkOutput("r_async_seg", seven_segment, 7'h3F);
      tick();
      checkOutput("r_hold_bin",   7'(binary_out), 7'h00);
      checkOutput("r_hold_valid", 7'(bin_valid),  7'h00);
      checkOutput("r_hold_err",   7'(step_err),   7'h00);
      rst = 1'b0;
      applyStimulus(4'b1001, 1'b0, 7, p);
      checkOutput("r_redo_pulses", 7'(p), 7'h00);
      tick();
      checkOutput("r_redo_valid", 7'(bin_valid), 7'h01);
      checkOutput("r_redo_bin", 7'(binary_out), 7'h0E);
      applyStimulus(4'b1011, 1'b0, 7, p);
      rst = 1'b1;
      tick();
      checkOutput("r_commit_bin",   7'(binary_out), 7'h00);
      checkOutput("r_commit_valid", 7'(bin_valid),  7'h00);
      rst = 1'b0;
      applyStimulus(4'b0000, 1'b0, 10, p);
      checkOutput("r_commit_pulses", 7'(p), 7'h00);
      checkOutput("r_commit_bin2", 7'(binary_out), 7'h00);

      $display("[TB] random stimulus");
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) g = gray_in ^ 4'(1 << $urandom_range(0, 3));
         else g = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 60) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         applyStimulus(g, ($urandom_range(0, 7) == 0), $urandom_range(1, 10), p);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gray_to_binary_display.md
GRAY_TO_BINARY_DISPLAY -- requirements
Module: gray_to_binary_display

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive clk cycles a synchronized input must hold before commit (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port gray_in, input, 4, raw Gray code from board switches, asynchronous to clk.
REQ-005 SHALL have port err_clr, input, 1, synchronous clear of step_err.
REQ-006 SHALL have port binary_out, output, 4, registered decoded binary value.
REQ-007 SHALL have port bin_valid, output, 1, single-cycle pulse when binary_out takes a newly committed value.
REQ-008 SHALL have port seven_segment, output, 7, registered segments {g,f,e,d,c,b,a}, active-high, hex glyph of binary_out.
REQ-009 SHALL have port step_err, output, 1, sticky flag: a committed code differed from the previous committed code in other than exactly one bit.

Function
REQ-010 SHALL pass gray_in through a 2-flop synchronizer; all downstream logic uses the second-flop output (sync).
REQ-011 SHALL hold a committed register stable[3:0] and run FSM IDLE, SETTLE, COMMIT.
REQ-012 IDLE: sync == stable -> stay; sync != stable -> SETTLE, candidate <= sync, counter <= 0.
REQ-013 SETTLE: sync != candidate -> candidate <= sync, counter <= 0, stay; sync == stable -> IDLE, no commit; counter == DEBOUNCE_CYCLES-1 with sync == candidate -> COMMIT; else counter increments.
REQ-014 COMMIT: stable <= candidate, one cycle, then IDLE unconditionally.
REQ-015 Conversion SHALL be b[3]=g[3], b[i]=b[i+1] XOR g[i] for i=2..0, applied to stable; binary_out and bin_valid register on the cycle after COMMIT.
REQ-016 bin_valid SHALL be high exactly one cycle per COMMIT, including commits equal in binary to the prior value (impossible by REQ-013, but no suppression logic).
REQ-017 seven_segment SHALL register one cycle after binary_out: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71 (hex).
REQ-018 Latency: gray_in held steady from first sampling edge -> binary_out updates on edge DEBOUNCE_CYCLES+4, seven_segment on edge DEBOUNCE_CYCLES+5.
REQ-019 Input bouncing shorter than DEBOUNCE_CYCLES SHALL produce no commit, no bin_valid, no output change.
REQ-020 err_clr and a step-error set in the same cycle: set wins, step_err stays 1.

Reset
REQ-021 rst SHALL asynchronously force: sync flops 0000, stable 0000, candidate 0000, counter 0, FSM IDLE, binary_out 0000, bin_valid 0, seven_segment 3F, step_err 0.
REQ-022 rst asserted mid-SETTLE or COMMIT SHALL abort without commit; no bin_valid after release until a new full debounce completes.

Configuration
REQ-023 Macro GRAY_STEP_CHECK_EN defined: on COMMIT, popcount(candidate XOR stable) != 1 sets step_err, cleared only by err_clr or rst.
REQ-024 Macro GRAY_STEP_CHECK_EN undefined: no check logic; step_err tied 0; err_clr ignored.

Verification (bench DEBOUNCE_CYCLES=4, GRAY_STEP_CHECK_EN defined)
REQ-025 Assert rst, gray_in=1010 -> binary_out=0000, seven_segment=3F, bin_valid=0, step_err=0 while rst high.
REQ-026 From 0000, set gray_in=0100 steady -> binary_out=0111 at edge 8, one bin_valid pulse, seven_segment=07 at edge 9, step_err=0.
REQ-027 From 0000, toggle gray_in 0000/0001 every 2 cycles for 20 cycles then hold 0000 -> no bin_valid, binary_out stays 0000.
REQ-028 From 0000, set gray_in=0011 steady -> binary_out=0010, step_err=1; pulse err_clr on the commit cycle of a further 0011->0000 step -> step_err remains 1; later lone err_clr -> 0.
REQ-029 Set gray_in=1000 steady -> binary_out=1111, seven_segment=71; assert rst during SETTLE of next change to 1001 -> outputs reset values, no bin_valid.
